// File: rtl/kempston_mouse.sv
// Kempston mouse port block: frame-coherent X/Y/button snapshot read via FADF/FBDF/FFDF.
// Latency: read data valid 1 clock after the IN cycle is first decoded.
// Backpressure: none; q is held for the whole IN cycle until iorq or rd drops.
module kempston_mouse #(
    parameter bit         FREEZE_ON_INT = 1'b1,
    parameter logic [4:0] BTN_FILL      = 5'b11111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        iorq,
    input  logic        rd,
    input  logic        m1,
    input  logic [15:0] a,
    input  logic        int_n,
    input  logic [7:0]  xaxis,
    input  logic [7:0]  yaxis,
    input  logic [2:0]  mbtns,
    output logic [7:0]  q,
    output logic        qe
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [2:0] sb;
    logic       int_q;
    logic       hit;
    logic       frame_edge;
    logic       shadow_ld;
    logic [7:0] sel_dat;
    logic [7:0] q_nxt;
    logic       qe_nxt;
    logic       unused_a;

    // Only a[7:0], a[8] and a[10] take part in the Kempston decode.
    assign unused_a = ^{a[15:11], a[9]};

    assign hit        = enable & iorq & rd & ~m1 & (a[7:0] == 8'hDF);
    assign frame_edge = int_q & ~int_n;
    assign shadow_ld  = FREEZE_ON_INT ? frame_edge : (state == IDLE);

    always_comb begin
        sel_dat = sx;
        if (!a[8]) begin
            sel_dat = {BTN_FILL, sb};
        end else if (a[10]) begin
            sel_dat = sy;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            int_q <= 1'b1;
            sx    <= 8'h00;
            sy    <= 8'h00;
            sb    <= 3'b111;
        end else begin
            int_q <= int_n;
            if (shadow_ld) begin
                sx <= xaxis;
                sy <= yaxis;
                sb <= mbtns;
            end
        end
    end

    // q is sampled from the pre-update shadows, so a frame edge coinciding
    // with the hit returns the previous frame's snapshot.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        qe_nxt    = qe;
        case (state)
            IDLE: begin
                qe_nxt = 1'b0;
                if (hit) begin
                    q_nxt     = sel_dat;
                    qe_nxt    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!enable || !iorq || !rd) begin
                    qe_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                qe_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            q     <= 8'hFF;
            qe    <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            qe    <= qe_nxt;
        end
    end

endmodule

// File: tb/tb_kempston_mouse.sv
// Directed bench for kempston_mouse: reads, frame snapshots, HOLD stability, non-decodes, reset.
module tb_kempston_mouse;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        iorq;
    logic        rd;
    logic        m1;
    logic [15:0] a;
    logic        int_n;
    logic [7:0]  xaxis;
    logic [7:0]  yaxis;
    logic [2:0]  mbtns;
    logic [7:0]  q;
    logic        qe;

    int n_checks = 0;
    int n_fail   = 0;

    kempston_mouse #(
        .FREEZE_ON_INT(1'b1),
        .BTN_FILL     (5'b11111)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .iorq  (iorq),
        .rd    (rd),
        .m1    (m1),
        .a     (a),
        .int_n (int_n),
        .xaxis (xaxis),
        .yaxis (yaxis),
        .mbtns (mbtns),
        .q     (q),
        .qe    (qe)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        @(negedge clock);
        a    = addr;
        iorq = 1'b1;
        rd   = 1'b1;
        #1 check({tag, "_lat"}, {7'd0, qe}, 8'd0);
        @(negedge clock);
        check({tag, "_qe"}, {7'd0, qe}, 8'd1);
        check({tag, "_q"}, q, exp);
        iorq = 1'b0;
        rd   = 1'b0;
        @(negedge clock);
        check({tag, "_end"}, {7'd0, qe}, 8'd0);
    endtask

    task automatic pulse_int();
        @(negedge clock);
        int_n = 1'b0;
        @(negedge clock);
        int_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic no_decode(input string tag);
        @(negedge clock);
        @(negedge clock);
        check(tag, {7'd0, qe}, 8'd0);
        iorq   = 1'b0;
        rd     = 1'b0;
        m1     = 1'b0;
        enable = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        iorq   = 1'b0;
        rd     = 1'b0;
        m1     = 1'b0;
        a      = 16'h0000;
        int_n  = 1'b1;
        xaxis  = 8'h00;
        yaxis  = 8'h00;
        mbtns  = 3'b111;

        #12;
        check("rst_q", q, 8'hFF);
        check("rst_qe", {7'd0, qe}, 8'd0);
        @(negedge clock);
        reset = 1'b1;

        bus_read(16'hFADF, 8'hFF, "btn_reset");
        bus_read(16'hFBDF, 8'h00, "x_reset");

        xaxis = 8'h12;
        yaxis = 8'h34;
        mbtns = 3'b101;
        pulse_int();
        bus_read(16'hFBDF, 8'h12, "x_frame");
        bus_read(16'hFFDF, 8'h34, "y_frame");
        bus_read(16'hFADF, 8'hFD, "btn_frame");
        xaxis = 8'h99;
        bus_read(16'hFBDF, 8'h12, "x_no_edge");

        // Frame edge and address change while an FFDF read is held.
        @(negedge clock);
        a    = 16'hFFDF;
        iorq = 1'b1;
        rd   = 1'b1;
        @(negedge clock);
        check("hold_qe", {7'd0, qe}, 8'd1);
        check("hold_q0", q, 8'h34);
        yaxis = 8'h77;
        int_n = 1'b0;
        @(negedge clock);
        int_n = 1'b1;
        a     = 16'hFBDF;
        @(negedge clock);
        check("hold_q1", q, 8'h34);
        check("hold_qe1", {7'd0, qe}, 8'd1);
        rd = 1'b0;
        @(negedge clock);
        check("hold_end_qe", {7'd0, qe}, 8'd0);
        check("hold_end_q", q, 8'h34);
        iorq = 1'b0;
        bus_read(16'hFFDF, 8'h77, "y_after_hold");

        // Hit and frame edge in the same clock.
        xaxis = 8'h10;
        pulse_int();
        xaxis = 8'h20;
        @(negedge clock);
        a     = 16'hFBDF;
        iorq  = 1'b1;
        rd    = 1'b1;
        int_n = 1'b0;
        @(negedge clock);
        int_n = 1'b1;
        check("same_clk_qe", {7'd0, qe}, 8'd1);
        check("same_clk_q", q, 8'h10);
        iorq = 1'b0;
        rd   = 1'b0;
        @(negedge clock);
        bus_read(16'hFBDF, 8'h20, "x_after_same");

        @(negedge clock);
        a    = 16'hFBDF;
        m1   = 1'b1;
        iorq = 1'b1;
        rd   = 1'b1;
        no_decode("nd_m1");
        @(negedge clock);
        a    = 16'hFB1F;
        iorq = 1'b1;
        rd   = 1'b1;
        no_decode("nd_addr");
        @(negedge clock);
        a      = 16'hFBDF;
        enable = 1'b0;
        iorq   = 1'b1;
        rd     = 1'b1;
        no_decode("nd_enable");

        // enable dropping mid-cycle releases the bus at once.
        @(negedge clock);
        a    = 16'hFBDF;
        iorq = 1'b1;
        rd   = 1'b1;
        @(negedge clock);
        check("en_hold_qe", {7'd0, qe}, 8'd1);
        enable = 1'b0;
        @(negedge clock);
        check("en_drop_qe", {7'd0, qe}, 8'd0);
        iorq   = 1'b0;
        rd     = 1'b0;
        enable = 1'b1;

        // Asynchronous reset while holding a button read.
        @(negedge clock);
        a    = 16'hFADF;
        iorq = 1'b1;
        rd   = 1'b1;
        @(negedge clock);
        check("pre_rst_q", q, 8'hFD);
        #2 reset = 1'b0;
        #1;
        check("async_rst_q", q, 8'hFF);
        check("async_rst_qe", {7'd0, qe}, 8'd0);
        iorq = 1'b0;
        rd   = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        bus_read(16'hFBDF, 8'h00, "x_post_rst");
        bus_read(16'hFFDF, 8'h00, "y_post_rst");
        bus_read(16'hFADF, 8'hFF, "btn_post_rst");
        pulse_int();
        bus_read(16'hFADF, 8'hFD, "btn_post_edge");
        bus_read(16'hFFDF, 8'h77, "y_post_edge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
